// File: rtl/obu_parser_pkg.sv
// Shared constants, types and helpers for the OBU parser front end.
package obu_parser_pkg;

   localparam int PARSER_DATA_WIDTH     = 32;
   localparam int PAD_LEN_WIDTH         = 6;
   localparam int BIT_SUPPLIER_BUF_BITS = 64;

   typedef enum logic [2:0] {
      NONE,
      POP,
      PAD,
      ALIGN,
      ILLEGAL
   } consume_sel_t;

   // Stream bytes are MSB first, while the bit buffer holds the oldest bit at index 0.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/obu_bit_consume_decode.sv
// Turns the parser's pad/pop/align requests into a bit consume amount and an error pulse.
module obu_bit_consume_decode
   import obu_parser_pkg::*;
#(
   parameter int W         = PARSER_DATA_WIDTH,
   parameter int PLW       = PAD_LEN_WIDTH,
   parameter int CNT_WIDTH = 7
) (
   input  logic                 pad,
   input  logic                 pop,
   input  logic                 align,
   input  logic [PLW-1:0]       pad_len,
   input  logic                 avail,
   input  logic [CNT_WIDTH-1:0] count,
   input  logic [2:0]           consumed_lsb,
   output logic [CNT_WIDTH-1:0] consume,
   output logic                 err_pulse
);

   consume_sel_t sel;
   logic [1:0]   req_count;
   logic [2:0]   align_amt;

   always_comb begin
      req_count = 2'(pad) + 2'(pop) + 2'(align);
      sel       = NONE;
      if (req_count > 2'd1) begin
         sel = ILLEGAL;
      end else if (pop) begin
         sel = POP;
      end else if (pad) begin
         sel = PAD;
      end else if (align) begin
         sel = ALIGN;
      end
   end

   // Distance to the next byte boundary is (-consumed) mod 8.
   always_comb begin
      consume   = '0;
      err_pulse = 1'b0;
      align_amt = 3'd0 - consumed_lsb;
      case (sel)
         POP: begin
            if (avail) begin
               consume = CNT_WIDTH'(W);
            end else begin
               err_pulse = 1'b1;
            end
         end
         PAD: begin
            if (!avail) begin
               err_pulse = 1'b1;
            end else if (pad_len == '0) begin
               consume = CNT_WIDTH'(W);
            end else if (int'(pad_len) >= W) begin
               err_pulse = 1'b1;
            end else begin
               consume = CNT_WIDTH'(W - int'(pad_len));
            end
         end
         ALIGN: begin
            if (count >= CNT_WIDTH'(align_amt)) begin
               consume = CNT_WIDTH'(align_amt);
            end else begin
               err_pulse = 1'b1;
            end
         end
         ILLEGAL: begin
            err_pulse = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/obu_bit_supplier.sv
// Packs the OBU byte stream into a bit buffer and serves a fixed-width window to the parsers.
module obu_bit_supplier
   import obu_parser_pkg::*;
#(
   parameter int PARSER_DATA_WIDTH = obu_parser_pkg::PARSER_DATA_WIDTH,
   parameter int PAD_LEN_WIDTH     = obu_parser_pkg::PAD_LEN_WIDTH,
   parameter int BUF_BITS          = BIT_SUPPLIER_BUF_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [PARSER_DATA_WIDTH-1:0] data_in,
   output logic                         avail,
   input  logic                         pad,
   input  logic [PAD_LEN_WIDTH-1:0]     pad_len,
   input  logic                         pop,
   input  logic                         align,
   input  logic                         clear,
   output logic [31:0]                  bits_consumed,
   output logic                         err
);

   localparam int CNT_WIDTH = $clog2(BUF_BITS + 1);

   logic [BUF_BITS-1:0]  bit_buf;
   logic [BUF_BITS-1:0]  buf_next;
   logic [CNT_WIDTH-1:0] count;
   logic [CNT_WIDTH-1:0] count_next;
   logic [CNT_WIDTH-1:0] count_after;
   logic [CNT_WIDTH-1:0] consume;
   logic                 err_pulse;
   logic                 fill;

   obu_bit_consume_decode #(
      .W         (PARSER_DATA_WIDTH),
      .PLW       (PAD_LEN_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_decode (
      .pad          (pad),
      .pop          (pop),
      .align        (align),
      .pad_len      (pad_len),
      .avail        (avail),
      .count        (count),
      .consumed_lsb (bits_consumed[2:0]),
      .consume      (consume),
      .err_pulse    (err_pulse)
   );

   // Readiness looks only at the current fill level so a same-cycle consume cannot create a loop.
   assign in_ready = !clear && (count <= CNT_WIDTH'(BUF_BITS - 8));
   assign fill     = in_valid && in_ready;
   assign avail    = count >= CNT_WIDTH'(PARSER_DATA_WIDTH);
   assign data_in  = bit_buf[PARSER_DATA_WIDTH-1:0];

   // Retire consumed bits first, then append the new byte just above what remains.
   always_comb begin
      count_after = count - consume;
      buf_next    = bit_buf >> consume;
      count_next  = count_after;
      if (fill) begin
         buf_next   = buf_next | (BUF_BITS'(bit_rev8(in_data)) << count_after);
         count_next = count_after + CNT_WIDTH'(8);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_buf       <= '0;
         count         <= '0;
         bits_consumed <= '0;
         err           <= 1'b0;
      end else if (clear) begin
         bit_buf       <= '0;
         count         <= '0;
         bits_consumed <= '0;
         err           <= 1'b0;
      end else begin
         bit_buf       <= buf_next;
         count         <= count_next;
         bits_consumed <= bits_consumed + 32'(consume);
         err           <= err | err_pulse;
      end
   end

endmodule

// File: tb/tb_obu_bit_supplier.sv
// Directed scoreboard bench for obu_bit_supplier: stimulus queues expected state, a negedge monitor checks it.
module tb_obu_bit_supplier;
   import obu_parser_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic        avail;
   logic        pad;
   logic [5:0]  pad_len;
   logic        pop;
   logic        align;
   logic        clear;
   logic [31:0] bits_consumed;
   logic        err;

   typedef struct {
      string       name;
      int          cyc;
      logic [31:0] data;
      logic        avail;
      logic        rdy;
      logic        err;
      logic [31:0] bc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   obu_bit_supplier dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data_in       (data_in),
      .avail         (avail),
      .pad           (pad),
      .pad_len       (pad_len),
      .pop           (pop),
      .align         (align),
      .clear         (clear),
      .bits_consumed (bits_consumed),
      .err           (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, field, act, expv);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp(e.name, "data_in", data_in, e.data);
      cmp(e.name, "avail", 32'(avail), 32'(e.avail));
      cmp(e.name, "in_ready", 32'(in_ready), 32'(e.rdy));
      cmp(e.name, "err", 32'(err), 32'(e.err));
      cmp(e.name, "bits_consumed", bits_consumed, e.bc);
   endtask

   // Inputs change just after the falling edge, so the monitor always sees settled idle inputs.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic pd, input logic [5:0] pl,
                                input logic pp, input logic al, input logic cl);
      @(negedge clk);
      #1;
      in_valid = v; in_data = d; pad = pd; pad_len = pl; pop = pp; align = al; clear = cl;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_data = 8'h00; pad = 1'b0; pad_len = 6'd0; pop = 1'b0; align = 1'b0; clear = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b1, b, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pushExpect(input string nm, input logic [31:0] d, input logic av, input logic rdy,
                             input logic er, input logic [31:0] bc);
      exp_t e;
      e.name = nm; e.cyc = cyc; e.data = d; e.avail = av; e.rdy = rdy; e.err = er; e.bc = bc;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         exp_t e;
         e = sbq.pop_front();
         if (e.cyc != cyc) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s.schedule: checked at cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
         end else begin
            checkOutput(e);
         end
      end
   end

   initial begin
      #200000;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected normal completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      logic [7:0] seq_a [4];
      seq_a[0] = 8'h12; seq_a[1] = 8'h34; seq_a[2] = 8'h56; seq_a[3] = 8'h78;
      in_valid = 1'b0; in_data = 8'h00; pad = 1'b0; pad_len = 6'd0;
      pop = 1'b0; align = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("reset", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);

      sendByte(8'h80);
      pushExpect("fill1", 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'd0);
      sendByte(8'h40); sendByte(8'h20); sendByte(8'h10);
      pushExpect("fill4", 32'h0804_0201, 1'b1, 1'b1, 1'b0, 32'd0);
      sendByte(8'hFF); sendByte(8'hFF);
      pushExpect("fill6", 32'h0804_0201, 1'b1, 1'b1, 1'b0, 32'd0);

      applyStimulus(1'b0, 8'h00, 1'b1, 6'd14, 1'b0, 1'b0, 1'b0);
      pushExpect("pad14", 32'h3FFF_C201, 1'b0, 1'b1, 1'b0, 32'd18);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      pushExpect("align6", 32'h00FF_FF08, 1'b0, 1'b1, 1'b0, 32'd24);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      pushExpect("align0", 32'h00FF_FF08, 1'b0, 1'b1, 1'b0, 32'd24);

      sendByte(8'hAA);
      pushExpect("fillAA", 32'h55FF_FF08, 1'b1, 1'b1, 1'b0, 32'd24);
      applyStimulus(1'b1, 8'hC3, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("popFill", 32'h0000_00C3, 1'b0, 1'b1, 1'b0, 32'd56);
      sendByte(8'h01);
      pushExpect("fill01", 32'h0000_80C3, 1'b0, 1'b1, 1'b0, 32'd56);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("popEmpty", 32'h0000_80C3, 1'b0, 1'b1, 1'b1, 32'd56);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("errSticky", 32'h0000_80C3, 1'b0, 1'b1, 1'b1, 32'd56);

      applyStimulus(1'b1, 8'h55, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
      pushExpect("clear", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);

      for (int i = 0; i < 4; i++) sendByte(seq_a[i]);
      pushExpect("fillB", 32'h1E6A_2C48, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0);
      pushExpect("padLenW", 32'h1E6A_2C48, 1'b1, 1'b1, 1'b1, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
      pushExpect("clear2", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);

      for (int i = 0; i < 4; i++) sendByte(seq_a[i]);
      applyStimulus(1'b0, 8'h00, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0);
      pushExpect("padPop", 32'h1E6A_2C48, 1'b1, 1'b1, 1'b1, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
      pushExpect("clear3", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);

      for (int i = 0; i < 4; i++) sendByte(seq_a[i]);
      sendByte(8'hF0);
      applyStimulus(1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("padLen0", 32'h0000_000F, 1'b0, 1'b1, 1'b0, 32'd32);

      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) sendByte(8'(i));
      pushExpect("full", 32'h20C0_4080, 1'b1, 1'b0, 1'b0, 32'd0);
      sendByte(8'h09);
      pushExpect("rejected", 32'h20C0_4080, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("popFull", 32'h10E0_60A0, 1'b1, 1'b1, 1'b0, 32'd32);

      // Reset is asserted mid-cycle and checked before the next rising edge.
      sendByte(8'hFF);
      #1 rst_n = 1'b0;
      pushExpect("asyncReset", 32'h0, 1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      begin
         int n = 0;
         while (sbq.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
         if (sbq.size() > 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sbq.size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
